// File: rtl/load_store_buffer.sv
// In-order load/store reservation buffer with CDB snooping and a word data memory.
// Define LSB_ALIGN_CHECK_EN to flag misaligned accesses on the extra misalign port.
module load_store_buffer #(
  parameter int unsigned DEPTH      = 4,
  parameter logic [3:0]  LABEL_BASE = 4'hC,
  parameter int unsigned MEM_LAT    = 2,
  parameter int unsigned MEM_WORDS  = 256
) (
  input  logic        clk,
  input  logic        nRST,
  input  logic        WEN,
  input  logic        opIn,
  input  logic [31:0] dataIn1,
  input  logic [3:0]  label1,
  input  logic [15:0] immd16,
  input  logic [31:0] dataIn2,
  input  logic [3:0]  label2,
  input  logic        BCEN,
  input  logic [3:0]  BClabel,
  input  logic [31:0] BCdata,
  output logic        isFull,
  output logic [3:0]  labelOut,
  output logic        require,
  input  logic        requireAC,
`ifdef LSB_ALIGN_CHECK_EN
  output logic        misalign,
`endif
  output logic [31:0] result,
  output logic [3:0]  resultLabel
);

  localparam int unsigned PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNTW = PW + 1;
  localparam int unsigned AW   = $clog2(MEM_WORDS);
  localparam int unsigned CW   = $clog2(MEM_LAT + 1);

  typedef enum logic [1:0] {ST_IDLE, ST_MEM, ST_CDB} state_t;

  state_t           state_q, state_d;
  logic [DEPTH-1:0] valid_q, valid_d;
  logic [DEPTH-1:0] op_q, op_d;
  logic [31:0]      vj_q [DEPTH];
  logic [31:0]      vj_d [DEPTH];
  logic [3:0]       qj_q [DEPTH];
  logic [3:0]       qj_d [DEPTH];
  logic [31:0]      vk_q [DEPTH];
  logic [31:0]      vk_d [DEPTH];
  logic [3:0]       qk_q [DEPTH];
  logic [3:0]       qk_d [DEPTH];
  logic [15:0]      imm_q [DEPTH];
  logic [15:0]      imm_d [DEPTH];
  logic [PW-1:0]    head_q, head_d, tail_q, tail_d;
  logic [CNTW-1:0]  count_q, count_d;
  logic             full_q, full_d;
  logic [AW-1:0]    word_q, word_d;
  logic             mis_q, mis_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             req_q, req_d;
  logic [31:0]      res_q, res_d;
  logic [3:0]       res_label_q, res_label_d;
`ifdef LSB_ALIGN_CHECK_EN
  logic             misalign_q, misalign_d;
`endif

  logic [31:0] mem [MEM_WORDS];
  logic        mem_we;
  logic        pop;
  logic        issue;
  logic        bc_valid;
  logic        head_ready;

  assign bc_valid   = BCEN && (BClabel != 4'h0);
  assign head_ready = valid_q[head_q] && (qj_q[head_q] == 4'h0) &&
                      (!op_q[head_q] || (qk_q[head_q] == 4'h0));

  always_comb begin
    state_d     = state_q;
    valid_d     = valid_q;
    op_d        = op_q;
    vj_d        = vj_q;
    qj_d        = qj_q;
    vk_d        = vk_q;
    qk_d        = qk_q;
    imm_d       = imm_q;
    head_d      = head_q;
    tail_d      = tail_q;
    word_d      = word_q;
    mis_d       = mis_q;
    cnt_d       = cnt_q;
    req_d       = req_q;
    res_d       = res_q;
    res_label_d = res_label_q;
`ifdef LSB_ALIGN_CHECK_EN
    misalign_d  = misalign_q;
`endif
    mem_we      = 1'b0;
    pop         = 1'b0;
    issue       = WEN && !full_q;

    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (valid_q[PW'(i)] && bc_valid) begin
        if (qj_q[PW'(i)] == BClabel) begin
          vj_d[PW'(i)] = BCdata;
          qj_d[PW'(i)] = 4'h0;
        end
        if (qk_q[PW'(i)] == BClabel) begin
          vk_d[PW'(i)] = BCdata;
          qk_d[PW'(i)] = 4'h0;
        end
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (head_ready) begin
          word_d = AW'((vj_q[head_q] + {{16{imm_q[head_q][15]}}, imm_q[head_q]}) >> 2);
`ifdef LSB_ALIGN_CHECK_EN
          mis_d = (2'(vj_q[head_q] + {{16{imm_q[head_q][15]}}, imm_q[head_q]}) != 2'b00);
          if (mis_d) misalign_d = 1'b1;
`else
          mis_d = 1'b0;
`endif
          cnt_d   = CW'(MEM_LAT - 1);
          state_d = ST_MEM;
        end
      end
      ST_MEM: begin
        if (cnt_q == '0) begin
          if (op_q[head_q]) begin
            mem_we  = !mis_q && !nRST;
            pop     = 1'b1;
            state_d = ST_IDLE;
          end else begin
            res_d       = mis_q ? 32'hDEADBEEF : mem[word_q];
            res_label_d = LABEL_BASE + 4'(head_q);
            req_d       = 1'b1;
            state_d     = ST_CDB;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      ST_CDB: begin
        if (requireAC) begin
          pop     = 1'b1;
          req_d   = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (pop) begin
      valid_d[head_q] = 1'b0;
      head_d          = head_q + PW'(1);
    end

    // Tail slot is never valid while not full, so issue cannot collide with snoop/pop.
    if (issue) begin
      valid_d[tail_q] = 1'b1;
      op_d[tail_q]    = opIn;
      imm_d[tail_q]   = immd16;
      if (bc_valid && (BClabel == label1)) begin
        vj_d[tail_q] = BCdata;
        qj_d[tail_q] = 4'h0;
      end else begin
        vj_d[tail_q] = dataIn1;
        qj_d[tail_q] = label1;
      end
      if (!opIn) begin
        vk_d[tail_q] = dataIn2;
        qk_d[tail_q] = 4'h0;
      end else if (bc_valid && (BClabel == label2)) begin
        vk_d[tail_q] = BCdata;
        qk_d[tail_q] = 4'h0;
      end else begin
        vk_d[tail_q] = dataIn2;
        qk_d[tail_q] = label2;
      end
      tail_d = tail_q + PW'(1);
    end

    count_d = count_q + CNTW'(issue) - CNTW'(pop);
    full_d  = (count_d == CNTW'(DEPTH));
  end

  always_ff @(posedge clk) begin
    if (nRST) begin
      state_q     <= ST_IDLE;
      valid_q     <= '0;
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      full_q      <= 1'b0;
      mis_q       <= 1'b0;
      cnt_q       <= '0;
      req_q       <= 1'b0;
      res_q       <= '0;
      res_label_q <= '0;
`ifdef LSB_ALIGN_CHECK_EN
      misalign_q  <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      valid_q     <= valid_d;
      op_q        <= op_d;
      vj_q        <= vj_d;
      qj_q        <= qj_d;
      vk_q        <= vk_d;
      qk_q        <= qk_d;
      imm_q       <= imm_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      full_q      <= full_d;
      word_q      <= word_d;
      mis_q       <= mis_d;
      cnt_q       <= cnt_d;
      req_q       <= req_d;
      res_q       <= res_d;
      res_label_q <= res_label_d;
`ifdef LSB_ALIGN_CHECK_EN
      misalign_q  <= misalign_d;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[word_q] <= vk_q[head_q];
  end

  assign isFull      = full_q;
  assign labelOut    = LABEL_BASE + 4'(tail_q);
  assign require     = req_q;
  assign result      = res_q;
  assign resultLabel = res_label_q;
`ifdef LSB_ALIGN_CHECK_EN
  assign misalign    = misalign_q;
`endif

endmodule

// File: tb/tb_load_store_buffer.sv
// Directed bench for load_store_buffer: issue, snoop, ordering, CDB handshake, reset abort.
module tb_load_store_buffer;

  logic        clk;
  logic        nRST;
  logic        WEN;
  logic        opIn;
  logic [31:0] dataIn1;
  logic [3:0]  label1;
  logic [15:0] immd16;
  logic [31:0] dataIn2;
  logic [3:0]  label2;
  logic        BCEN;
  logic [3:0]  BClabel;
  logic [31:0] BCdata;
  logic        isFull;
  logic [3:0]  labelOut;
  logic        require;
  logic        requireAC;
  logic [31:0] result;
  logic [3:0]  resultLabel;

  int n_cmp  = 0;
  int n_fail = 0;

  load_store_buffer #(
    .DEPTH      (4),
    .LABEL_BASE (4'hC),
    .MEM_LAT    (2),
    .MEM_WORDS  (256)
  ) dut (
    .clk         (clk),
    .nRST        (nRST),
    .WEN         (WEN),
    .opIn        (opIn),
    .dataIn1     (dataIn1),
    .label1      (label1),
    .immd16      (immd16),
    .dataIn2     (dataIn2),
    .label2      (label2),
    .BCEN        (BCEN),
    .BClabel     (BClabel),
    .BCdata      (BCdata),
    .isFull      (isFull),
    .labelOut    (labelOut),
    .require     (require),
    .requireAC   (requireAC),
    .result      (result),
    .resultLabel (resultLabel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic op, input logic [31:0] d1, input logic [3:0] l1,
                       input logic [15:0] imm, input logic [31:0] d2, input logic [3:0] l2);
    WEN     = 1'b1;
    opIn    = op;
    dataIn1 = d1;
    label1  = l1;
    immd16  = imm;
    dataIn2 = d2;
    label2  = l2;
  endtask

  task automatic serve(input string tag, input logic [31:0] er, input logic [3:0] el);
    int n = 0;
    while (require !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk({tag, "_req"}, 32'(require), 32'd1);
    chk({tag, "_res"}, result, er);
    chk({tag, "_lbl"}, 32'(resultLabel), 32'(el));
    requireAC = 1'b1;
    tick();
    requireAC = 1'b0;
    chk({tag, "_drop"}, 32'(require), 32'd0);
  endtask

  initial begin
    nRST = 1'b1; WEN = 1'b0; opIn = 1'b0; dataIn1 = '0; label1 = '0; immd16 = '0;
    dataIn2 = '0; label2 = '0; BCEN = 1'b0; BClabel = '0; BCdata = '0; requireAC = 1'b0;
    tick();
    tick();
    chk("rst_full", 32'(isFull), 32'd0);
    chk("rst_req", 32'(require), 32'd0);
    chk("rst_res", result, 32'd0);
    chk("rst_rlbl", 32'(resultLabel), 32'd0);
    chk("rst_lblout", 32'(labelOut), 32'hC);
    nRST = 1'b0;
    tick();

    // 1: sw then lw to addr 0x10; label2 on the lw must be ignored
    drive(1'b1, 32'h8, 4'h0, 16'h0008, 32'hA5A5A5A5, 4'h0);
    chk("t1_lbl_sw", 32'(labelOut), 32'hC);
    tick();
    drive(1'b0, 32'h8, 4'h0, 16'h0008, 32'h0, 4'h5);
    chk("t1_lbl_lw", 32'(labelOut), 32'hD);
    tick();
    WEN = 1'b0;
    for (int k = 0; k < 5; k++) begin
      chk("t1_noreq", 32'(require), 32'd0);
      tick();
    end
    chk("t1_req", 32'(require), 32'd1);
    chk("t1_res", result, 32'hA5A5A5A5);
    chk("t1_rlbl", 32'(resultLabel), 32'hD);
    requireAC = 1'b1;
    tick();
    requireAC = 1'b0;
    chk("t1_drop", 32'(require), 32'd0);

    // 2: lw waiting on label 2, broadcast releases it; reads word 0x41
    drive(1'b1, 32'h100, 4'h0, 16'h0004, 32'h12345678, 4'h0);
    chk("t2_lbl_sw", 32'(labelOut), 32'hE);
    tick();
    drive(1'b0, 32'h0, 4'h2, 16'h0004, 32'h0, 4'h0);
    chk("t2_lbl_lw", 32'(labelOut), 32'hF);
    tick();
    WEN = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk("t2_idle", 32'(require), 32'd0);
      tick();
    end
    BCEN = 1'b1; BClabel = 4'h2; BCdata = 32'h100;
    tick();
    BCEN = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk("t2_noreq", 32'(require), 32'd0);
      tick();
    end
    chk("t2_req", 32'(require), 32'd1);
    chk("t2_res", result, 32'h12345678);
    chk("t2_rlbl", 32'(resultLabel), 32'hF);
    requireAC = 1'b1;
    tick();
    requireAC = 1'b0;

    // 3/4: fill, drop 5th issue, hold CDB grant low, refill after pop
    for (int k = 0; k < 4; k++) begin
      drive(1'b0, 32'h0, 4'h2, (k == 1) ? 16'hFF10 : 16'h0004, 32'h0, 4'h0);
      chk("t3_lbl", 32'(labelOut), 32'hC + 32'(k));
      chk("t3_notfull", 32'(isFull), 32'd0);
      tick();
    end
    chk("t3_full", 32'(isFull), 32'd1);
    drive(1'b0, 32'h100, 4'h0, 16'h0000, 32'h0, 4'h0);
    tick();
    WEN = 1'b0;
    chk("t3_drop5", 32'(isFull), 32'd1);
    BCEN = 1'b1; BClabel = 4'h2; BCdata = 32'h100;
    tick();
    BCEN = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk("t3_noreq", 32'(require), 32'd0);
      tick();
    end
    for (int k = 0; k < 5; k++) begin
      chk("t4_hold_req", 32'(require), 32'd1);
      chk("t4_hold_res", result, 32'h12345678);
      chk("t4_hold_lbl", 32'(resultLabel), 32'hC);
      chk("t4_hold_full", 32'(isFull), 32'd1);
      if (k < 4) tick();
    end
    requireAC = 1'b1;
    tick();
    requireAC = 1'b0;
    chk("t4_pop_req", 32'(require), 32'd0);
    chk("t3_unfull", 32'(isFull), 32'd0);
    drive(1'b0, 32'h100, 4'h0, 16'h0004, 32'h0, 4'h0);
    chk("t3_reuse_lbl", 32'(labelOut), 32'hC);
    tick();
    WEN = 1'b0;
    chk("t3_refull", 32'(isFull), 32'd1);
    for (int k = 0; k < 2; k++) begin
      chk("t4_next_wait", 32'(require), 32'd0);
      tick();
    end
    chk("t4_next_req", 32'(require), 32'd1);
    chk("t4_next_res", result, 32'hA5A5A5A5);
    chk("t4_next_lbl", 32'(resultLabel), 32'hD);
    requireAC = 1'b1;
    tick();
    requireAC = 1'b0;
    serve("t3_e", 32'h12345678, 4'hE);
    serve("t3_f", 32'h12345678, 4'hF);
    serve("t3_c", 32'h12345678, 4'hC);

    // 5: issue-time forwarding of base operand
    drive(1'b0, 32'h0, 4'h1, 16'hFFF0, 32'h0, 4'h0);
    BCEN = 1'b1; BClabel = 4'h1; BCdata = 32'h20;
    chk("t5_lbl", 32'(labelOut), 32'hD);
    tick();
    WEN = 1'b0;
    BCEN = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk("t5_noreq", 32'(require), 32'd0);
      tick();
    end
    chk("t5_req", 32'(require), 32'd1);
    chk("t5_res", result, 32'hA5A5A5A5);
    chk("t5_rlbl", 32'(resultLabel), 32'hD);
    requireAC = 1'b1;
    tick();
    requireAC = 1'b0;

    // 6: reset during sw's final memory cycle suppresses the write
    drive(1'b1, 32'h10, 4'h0, 16'h0000, 32'hFFFFFFFF, 4'h0);
    chk("t6_lbl", 32'(labelOut), 32'hE);
    tick();
    WEN = 1'b0;
    tick();
    tick();
    nRST = 1'b1;
    tick();
    nRST = 1'b0;
    chk("t6_full", 32'(isFull), 32'd0);
    chk("t6_req", 32'(require), 32'd0);
    chk("t6_res", result, 32'd0);
    chk("t6_lblout", 32'(labelOut), 32'hC);
    drive(1'b0, 32'h10, 4'h0, 16'h0000, 32'h0, 4'h0);
    tick();
    WEN = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk("t6_noreq", 32'(require), 32'd0);
      tick();
    end
    chk("t6_rd_req", 32'(require), 32'd1);
    chk("t6_mem_kept", result, 32'hA5A5A5A5);
    chk("t6_rd_lbl", 32'(resultLabel), 32'hC);
    requireAC = 1'b1;
    tick();
    requireAC = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
